// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: states, opcode/funct
// constants, ALU control codes and datapath select encodings.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQ     = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd6;
   localparam logic [2:0] ALU_SLT = 3'd7;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// ALU control decoder: fixed ADD/SUB or funct-driven operation select,
// plus a flag telling whether the funct code is one we support.
module alu_dec
   import mc_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctl,
   output logic       funct_valid
);

   logic [2:0] funct_ctl;

   always_comb begin
      funct_ctl   = ALU_ADD;
      funct_valid = 1'b1;
      case (funct)
         FN_ADD:  funct_ctl = ALU_ADD;
         FN_SUB:  funct_ctl = ALU_SUB;
         FN_AND:  funct_ctl = ALU_AND;
         FN_OR:   funct_ctl = ALU_OR;
         FN_SLT:  funct_ctl = ALU_SLT;
         default: begin
            funct_ctl   = ALU_ADD;
            funct_valid = 1'b0;
         end
      endcase
   end

   always_comb begin
      case (alu_op)
         ALUOP_SUB:   alu_ctl = ALU_SUB;
         ALUOP_FUNCT: alu_ctl = funct_ctl;
         default:     alu_ctl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle processor control FSM (Moore, one cycle per state).
//   state   | meaning
//   FETCH   | read instruction, load IR, PC <= PC + 4
//   DECODE  | compute branch target, dispatch on Op
//   MEMADR  | compute load/store address
//   MEMRD   | read data memory
//   MEMWB   | write loaded data to rt
//   MEMWR   | write data memory
//   EXEC    | R-type ALU operation
//   RTYPEWB | write ALU result to rd
//   BEQ     | compare, load PC from branch target if Zero
//   ADDIEX  | add immediate
//   ADDIWB  | write ALU result to rt
//   JUMP    | load PC from jump target
module mc_ctrl
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [2:0] ALUCtl,
   output logic [3:0] State
);

   state_t     state;
   state_t     state_nx;
   logic [1:0] alu_op;
   logic       alu_en;
   logic [2:0] dec_ctl;
   logic       funct_valid;

   alu_dec u_alu_dec (
      .alu_op      (alu_op),
      .funct       (Funct),
      .alu_ctl     (dec_ctl),
      .funct_valid (funct_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = S_FETCH;
      case (state)
         S_FETCH:  state_nx = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_nx = S_MEMADR;
               OP_RTYPE:     state_nx = S_EXEC;
               OP_BEQ:       state_nx = S_BEQ;
               OP_ADDI:      state_nx = S_ADDIEX;
               OP_J:         state_nx = S_JUMP;
               default:      state_nx = S_FETCH;
            endcase
         end
         S_MEMADR: state_nx = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_nx = S_MEMWB;
         S_EXEC:   state_nx = S_RTYPEWB;
         S_ADDIEX: state_nx = S_ADDIWB;
         default:  state_nx = S_FETCH;
      endcase
   end

   always_comb begin
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = SRCB_B;
      PCSource = PCSRC_ALU;
      alu_op   = ALUOP_ADD;
      alu_en   = 1'b0;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            IRWrite = 1'b1;
            ALUSrcB = SRCB_FOUR;
            alu_en  = 1'b1;
            PCWrite = 1'b1;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMM_SH;
            alu_en  = 1'b1;
         end
         S_MEMADR, S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            alu_en  = 1'b1;
         end
         S_MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            alu_op  = ALUOP_FUNCT;
            alu_en  = 1'b1;
         end
         S_RTYPEWB: begin
            RegDst   = 1'b1;
            RegWrite = funct_valid;
         end
         S_BEQ: begin
            ALUSrcA  = 1'b1;
            alu_op   = ALUOP_SUB;
            alu_en   = 1'b1;
            PCSource = PCSRC_ALUOUT;
            PCWrite  = Zero;
         end
         S_ADDIWB: RegWrite = 1'b1;
         S_JUMP: begin
            PCSource = PCSRC_JUMP;
            PCWrite  = 1'b1;
         end
         default: ;
      endcase
      ALUCtl = alu_en ? dec_ctl : 3'd0;
      // Reset kills every strobe immediately so an abandoned store never writes.
      if (rst) begin
         PCWrite  = 1'b0;
         IorD     = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegDst   = 1'b0;
         MemtoReg = 1'b0;
         RegWrite = 1'b0;
         ALUSrcA  = 1'b0;
         ALUSrcB  = 2'b00;
         PCSource = 2'b00;
         ALUCtl   = 3'd0;
      end
   end

   assign State = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: expected per-cycle control vectors are
// queued with the stimulus and compared against the DUT at each falling edge.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       PCWrite, IorD, MemRead, MemWrite, IRWrite;
   logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALUCtl;
   logic [3:0] State;

   localparam logic [3:0] ST_FETCH   = 4'd0;
   localparam logic [3:0] ST_DECODE  = 4'd1;
   localparam logic [3:0] ST_MEMADR  = 4'd2;
   localparam logic [3:0] ST_MEMRD   = 4'd3;
   localparam logic [3:0] ST_MEMWB   = 4'd4;
   localparam logic [3:0] ST_MEMWR   = 4'd5;
   localparam logic [3:0] ST_EXEC    = 4'd6;
   localparam logic [3:0] ST_RTYPEWB = 4'd7;
   localparam logic [3:0] ST_BEQ     = 4'd8;
   localparam logic [3:0] ST_ADDIEX  = 4'd9;
   localparam logic [3:0] ST_ADDIWB  = 4'd10;
   localparam logic [3:0] ST_JUMP    = 4'd11;

   int total = 0;
   int bad   = 0;
   int ncyc  = 0;
   logic [19:0] sb[$];
   logic [19:0] obs;

   mc_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .Op       (Op),
      .Funct    (Funct),
      .Zero     (Zero),
      .PCWrite  (PCWrite),
      .IorD     (IorD),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .IRWrite  (IRWrite),
      .RegDst   (RegDst),
      .MemtoReg (MemtoReg),
      .RegWrite (RegWrite),
      .ALUSrcA  (ALUSrcA),
      .ALUSrcB  (ALUSrcB),
      .PCSource (PCSource),
      .ALUCtl   (ALUCtl),
      .State    (State)
   );

   always #5 clk = ~clk;

   assign obs = {State, PCWrite, IorD, MemRead, MemWrite, IRWrite,
                 RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUCtl};

   task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
      end
   endtask

   // strobes = {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA}
   function automatic logic [19:0] ev(input logic [3:0] st, input logic [8:0] strobes,
                                      input logic [1:0] srcb, input logic [1:0] pcs,
                                      input logic [2:0] alu);
      return {st, strobes, srcb, pcs, alu};
   endfunction

   function automatic logic [19:0] v_fetch();  return ev(ST_FETCH,  9'b1_0_1_0_1_0_0_0_0, 2'b01, 2'b00, 3'd2); endfunction
   function automatic logic [19:0] v_decode(); return ev(ST_DECODE, 9'b0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 3'd2); endfunction
   function automatic logic [19:0] v_memadr(); return ev(ST_MEMADR, 9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 3'd2); endfunction
   function automatic logic [19:0] v_memrd();  return ev(ST_MEMRD,  9'b0_1_1_0_0_0_0_0_0, 2'b00, 2'b00, 3'd0); endfunction
   function automatic logic [19:0] v_memwb();  return ev(ST_MEMWB,  9'b0_0_0_0_0_0_1_1_0, 2'b00, 2'b00, 3'd0); endfunction
   function automatic logic [19:0] v_memwr();  return ev(ST_MEMWR,  9'b0_1_0_1_0_0_0_0_0, 2'b00, 2'b00, 3'd0); endfunction
   function automatic logic [19:0] v_addiex(); return ev(ST_ADDIEX, 9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 3'd2); endfunction
   function automatic logic [19:0] v_addiwb(); return ev(ST_ADDIWB, 9'b0_0_0_0_0_0_0_1_0, 2'b00, 2'b00, 3'd0); endfunction
   function automatic logic [19:0] v_jump();   return ev(ST_JUMP,   9'b1_0_0_0_0_0_0_0_0, 2'b00, 2'b10, 3'd0); endfunction
   function automatic logic [19:0] v_exec(input logic [2:0] c);
      return ev(ST_EXEC, 9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, c);
   endfunction
   function automatic logic [19:0] v_rtwb(input logic rw);
      return ev(ST_RTYPEWB, {5'b0, 1'b1, 1'b0, rw, 1'b0}, 2'b00, 2'b00, 3'd0);
   endfunction
   function automatic logic [19:0] v_beq(input logic z);
      return ev(ST_BEQ, {z, 7'b0, 1'b1}, 2'b00, 2'b01, 3'd6);
   endfunction
   function automatic logic [19:0] v_rst(input logic [3:0] st);
      return ev(st, 9'b0, 2'b00, 2'b00, 3'd0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [19:0] e);
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         ncyc++;
         chk($sformatf("cyc%0d", ncyc), obs, sb.pop_front());
         chk("mem_rd_wr_excl", {19'b0, MemRead & MemWrite}, 20'd0);
         chk("reg_mem_wr_excl", {19'b0, RegWrite & MemWrite}, 20'd0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   logic [5:0] fn_tab  [6] = '{6'h2A, 6'h27, 6'h20, 6'h22, 6'h24, 6'h25};
   logic [2:0] ctl_tab [6] = '{3'd7, 3'd2, 3'd2, 3'd6, 3'd0, 3'd1};
   logic       ok_tab  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   initial begin
      rst = 1'b1; Op = 6'h00; Funct = 6'h00; Zero = 1'b0;
      tick(); tick();
      push(v_rst(ST_FETCH)); tick();

      // lw
      rst = 1'b0; Op = 6'h23;
      push(v_fetch());  tick();
      push(v_decode()); tick();
      push(v_memadr()); tick();
      push(v_memrd());  tick();
      push(v_memwb());  tick();

      // sw
      Op = 6'h2B;
      push(v_fetch());  tick();
      push(v_decode()); tick();
      push(v_memadr()); tick();
      push(v_memwr());  tick();

      // R-types, including an unsupported funct
      for (int i = 0; i < 6; i++) begin
         Op = 6'h00; Funct = fn_tab[i];
         push(v_fetch());          tick();
         push(v_decode());         tick();
         push(v_exec(ctl_tab[i])); tick();
         push(v_rtwb(ok_tab[i]));  tick();
      end

      // beq taken then not taken
      for (int z = 1; z >= 0; z--) begin
         Op = 6'h04; Zero = z[0];
         push(v_fetch());     tick();
         push(v_decode());    tick();
         push(v_beq(z[0]));   tick();
      end
      Zero = 1'b0;

      // addi
      Op = 6'h08;
      push(v_fetch());  tick();
      push(v_decode()); tick();
      push(v_addiex()); tick();
      push(v_addiwb()); tick();

      // sw abandoned by reset in MEMADR
      Op = 6'h2B;
      push(v_fetch());  tick();
      push(v_decode()); tick();
      rst = 1'b1;
      push(v_rst(ST_MEMADR)); tick();
      rst = 1'b0; Op = 6'h3F;
      push(v_fetch());  tick();
      push(v_decode()); tick();

      // j
      Op = 6'h02;
      push(v_fetch());  tick();
      push(v_decode()); tick();
      push(v_jump());   tick();
      push(v_fetch());  tick();

      @(negedge clk);
      #1;
      chk("sb_drain", 20'(sb.size()), 20'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 No parameters; all encodings are fixed constants.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 Op  in  6  opcode field from the external instruction register; valid from DECODE onward.
REQ-005 Funct  in  6  funct field from the external instruction register; valid from DECODE onward.
REQ-006 Zero  in  1  ALU zero flag; sampled only in BEQ.
REQ-007 PCWrite  out  1  PC load enable; branch qualification with Zero is internal.
REQ-008 IorD, MemRead, MemWrite, IRWrite  out  1 each  memory address select (1 = ALUOut), read strobe, write strobe, IR load.
REQ-009 RegDst, MemtoReg, RegWrite, ALUSrcA  out  1 each  rd/rt select (1 = rd), writeback source (1 = MDR), regfile write, ALU A select (1 = register A, 0 = PC).
REQ-010 ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-011 PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-012 ALUCtl  out  3  0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT.
REQ-013 State  out  4  current state encoding (debug).

Function
REQ-014 Moore FSM; registered state; outputs decoded combinationally from state, except PCWrite in BEQ, which equals Zero.
REQ-015 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RTYPEWB, BEQ, ADDIEX, ADDIWB, JUMP; every state lasts exactly one cycle.
REQ-016 FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtl=ADD, PCSource=00, PCWrite=1; next state is DECODE.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ALUCtl=ADD; next state by Op: 0x23/0x2B -> MEMADR, 0x00 -> EXEC, 0x04 -> BEQ, 0x08 -> ADDIEX, 0x02 -> JUMP, any other Op -> FETCH (executes as a NOP).
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; next state is MEMRD if Op=0x23, else MEMWR.
REQ-019 MEMRD: IorD=1, MemRead=1; next state is MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next state is FETCH.
REQ-020 MEMWR: IorD=1, MemWrite=1; next state is FETCH.
REQ-021 EXEC: ALUSrcA=1, ALUSrcB=00, ALUCtl from Funct (0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, any other ADD); next state is RTYPEWB.
REQ-022 RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1 only if Funct is one of the five supported codes, else RegWrite=0; next state is FETCH.
REQ-023 BEQ: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCWrite=Zero; next state is FETCH.
REQ-024 ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD; next state is ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next state is FETCH.
REQ-025 JUMP: PCSource=10, PCWrite=1; next state is FETCH.
REQ-026 Every output not listed for a state is 0.
REQ-027 Instruction latencies (FETCH to FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported Op 2.
REQ-028 MemRead and MemWrite are never both 1 in the same cycle, and RegWrite and MemWrite are never both 1 in the same cycle.
REQ-029 Op and Funct are not latched; the surrounding datapath holds the IR stable from DECODE until the next FETCH.

Reset
REQ-030 While rst=1, State is FETCH on the next edge and all control outputs are forced to 0 combinationally.
REQ-031 Reset asserted mid-instruction abandons the instruction; no write strobe is issued during or after reset for that instruction.
REQ-032 The first cycle after rst deasserts is FETCH with FETCH outputs.

Structure
REQ-033 Package mc_pkg contains the state enumeration, Op and Funct constants, ALUCtl codes, and ALUSrcB/PCSource select encodings.
REQ-034 One sub-module, alu_dec, maps a 2-bit ALUOp (ADD, SUB, FUNCT) plus Funct to ALUCtl and a funct_valid flag.

Verification
REQ-035 Reset then lw (Op=0x23): State sequence FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; RegWrite=1 with MemtoReg=1 only in cycle 5.
REQ-036 R-type with Funct=0x2A: EXEC drives ALUCtl=7; RTYPEWB drives RegDst=1, RegWrite=1; with Funct=0x27, RegWrite=0 in RTYPEWB.
REQ-037 beq (Op=0x04) run once with Zero=1 and once with Zero=0: PCWrite=1 with PCSource=01 in BEQ for the first run; PCWrite=0 for the second.
REQ-038 sw (Op=0x2B) with rst pulsed during MEMADR: MemWrite never asserts; the next state is FETCH.
REQ-039 Op=0x3F: DECODE -> FETCH in 2 cycles with no write strobes; then j (Op=0x02): PCSource=10 and PCWrite=1 in the third cycle.
